i2c_txn_arbiter: RTL and testbench

Shares the single multi-byte I2C master (start/stop/data_valid/data_req/busy handshake) between two transaction sources, typically the SSD1306 init sequencer on port 0 and the framebuffer/page writer on port 1. It owns each bus transaction from `start` to the master's release of `busy`, so transactions are never interleaved. Arbitration is round-robin per transaction. An optional watchdog force-terminates a stalled owner.

---
 rtl/i2c_txn_arbiter.sv | 155 +++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// Round-robin, per-transaction sharing of one I2C byte master between two sources.
// Define I2C_ARB_TIMEOUT_EN to add the stalled-owner watchdog (ABORT state).
module i2c_txn_arbiter #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_start,
    input  logic [1:0] req_stop,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    output logic [1:0] req_data_req,
    output logic [1:0] req_busy,
    output logic [1:0] grant,
    output logic       txn_abort,
    output logic       m_start,
    output logic       m_stop,
    output logic       m_data_valid,
    output logic [7:0] m_data,
    input  logic       m_data_req,
    input  logic       m_busy
);
`ifdef I2C_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ABORT  = 2'd2,
        DRAIN  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd3
    } state_t;
`endif

    state_t     r_state;
    logic [1:0] r_grant;
    logic [1:0] r_pend;
    logic       r_rr;
    logic       r_start;

    logic       w_active;
    logic       w_own;
    logic       w_win;
    logic       w_go;
    logic       w_fwd_valid;
    logic       w_fwd_stop;
    logic [1:0] w_clr;
    logic [1:0] w_pend_next;

    assign w_active    = (r_state == ACTIVE);
    assign w_own       = r_grant[1];
    // Prefer the port that did not own the bus last; else the lone requester.
    assign w_win       = r_pend[~r_rr] ? ~r_rr : r_rr;
    assign w_go        = (r_state == IDLE) && (|r_pend) && !m_busy;
    assign w_clr       = w_go ? (2'b01 << w_win) : 2'b00;
    assign w_pend_next = (r_pend | (req_start & ~r_grant)) & ~w_clr;
    assign w_fwd_valid = w_active && (|(req_valid & r_grant));
    assign w_fwd_stop  = w_fwd_valid && (|(req_stop & r_grant));

    assign grant    = r_grant;
    assign m_start  = r_start;
    assign req_busy = {2{m_busy || (r_state != IDLE)}} | r_pend;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] r_wd;
    logic           r_abort;
    logic           w_wd_fire;

    assign w_wd_fire = w_active && !w_fwd_valid
                       && (r_wd == WDW'(TIMEOUT_CYCLES - 1));
    assign txn_abort = r_abort;
`else
    assign txn_abort = 1'b0;
`endif

    always_comb begin
        m_data_valid = w_fwd_valid;
        m_stop       = w_fwd_stop;
        m_data       = 8'h00;
        req_data_req = 2'b00;
        if (w_active) begin
            m_data       = w_own ? req_data1 : req_data0;
            req_data_req = r_grant & {2{m_data_req}};
        end
`ifdef I2C_ARB_TIMEOUT_EN
        // Close the aborted transaction with a dummy stop byte.
        if (r_state == ABORT) begin
            m_data_valid = m_data_req;
            m_stop       = m_data_req;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
            r_pend  <= 2'b00;
            r_rr    <= 1'b1;
            r_start <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            r_wd    <= '0;
            r_abort <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            r_pend  <= w_pend_next;
`ifdef I2C_ARB_TIMEOUT_EN
            r_abort <= w_wd_fire;
            if (!w_active || w_fwd_valid)
                r_wd <= '0;
            else
                r_wd <= r_wd + 1'b1;
`endif
            unique case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_grant <= 2'b01 << w_win;
                        r_start <= 1'b1;
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_fwd_stop)
                        r_state <= DRAIN;
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (w_wd_fire)
                        r_state <= ABORT;
`endif
                end
`ifdef I2C_ARB_TIMEOUT_EN
                ABORT: begin
                    if (m_data_req)
                        r_state <= DRAIN;
                end
`endif
                DRAIN: begin
                    if (!m_busy) begin
                        r_grant <= 2'b00;
                        r_rr    <= w_own;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomized bench for i2c_txn_arbiter with a behavioural I2C master and
// a transaction-level scoreboard of round-robin order and byte streams.
module tb_i2c_txn_arbiter;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO = 50;
`else
    localparam int TO = 100000;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_start = 2'b00;
    logic [1:0] req_stop = 2'b00;
    logic [1:0] req_valid = 2'b00;
    logic [7:0] req_data0 = 8'h00;
    logic [7:0] req_data1 = 8'h00;
    logic [1:0] req_data_req, req_busy, grant;
    logic       txn_abort, m_start, m_stop, m_data_valid;
    logic [7:0] m_data;
    logic       m_data_req, m_busy;

    int errors = 0;
    int checks = 0;
    int rr_m = 1;

    logic [10:0] log_q[$];
    logic [10:0] exp_q[$];
    logic [1:0]  st_q[$];
    logic [1:0]  exp_st[$];
    logic [7:0]  tx0[$];
    logic [7:0]  tx1[$];

    always #5 clk = ~clk;

    i2c_txn_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_start(req_start), .req_stop(req_stop), .req_valid(req_valid),
        .req_data0(req_data0), .req_data1(req_data1),
        .req_data_req(req_data_req), .req_busy(req_busy), .grant(grant),
        .txn_abort(txn_abort), .m_start(m_start), .m_stop(m_stop),
        .m_data_valid(m_data_valid), .m_data(m_data),
        .m_data_req(m_data_req), .m_busy(m_busy)
    );

    // Master: busy from the cycle after m_start, data_req held until a byte
    // is accepted, busy released a few cycles after the stop byte.
    int mph = 0;
    int mcnt = 0;
    logic s_st, s_v, s_sp;
    logic [7:0] s_d;
    logic [1:0] s_g;
    initial begin
        m_busy = 1'b0;
        m_data_req = 1'b0;
        forever begin
            @(negedge clk);
            s_st = m_start; s_v = m_data_valid; s_sp = m_stop;
            s_d = m_data; s_g = grant;
            if (rst_n && s_st) st_q.push_back(s_g);
            if (rst_n && s_v) log_q.push_back({s_g, s_sp, s_d});
            @(posedge clk); #1;
            if (!rst_n) begin
                m_busy = 1'b0; m_data_req = 1'b0; mph = 0;
            end else begin
                case (mph)
                    0: if (s_st) begin
                        m_busy = 1'b1; mcnt = $urandom_range(0, 2); mph = 1;
                    end
                    1: if (mcnt == 0) begin
                        m_data_req = 1'b1; mph = 2;
                    end else mcnt--;
                    2: if (s_v) begin
                        m_data_req = 1'b0;
                        mcnt = s_sp ? $urandom_range(1, 3) : $urandom_range(0, 2);
                        mph = s_sp ? 3 : 1;
                    end
                    default: if (mcnt == 0) begin
                        m_busy = 1'b0; mph = 0;
                    end else mcnt--;
                endcase
            end
        end
    end

    function automatic logic [1:0] oh(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    // Round-robin rule: on a tie the port that was not last owner wins.
    function automatic int pick(input logic [1:0] pend, input int rr);
        if (pend == 2'b11) return 1 - rr;
        return pend[1] ? 1 : 0;
    endfunction

    task automatic gen(input int p, input int n, input int first, input bit no_ff);
        logic [7:0] b;
        if (p == 0) tx0.delete(); else tx1.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, no_ff ? 254 : 255));
            if (i == 0 && first >= 0) b = 8'(first);
            if (p == 0) tx0.push_back(b); else tx1.push_back(b);
        end
    endtask

    task automatic add_exp(input int p, input int n, input bit stop_last);
        for (int i = 0; i < n; i++)
            exp_q.push_back({oh(p), stop_last && (i == n - 1), (p == 0) ? tx0[i] : tx1[i]});
    endtask

    task automatic clear_logs();
        log_q.delete(); exp_q.delete(); st_q.delete(); exp_st.delete();
    endtask

    task automatic pulse(input logic [1:0] m);
        @(posedge clk); #1; req_start = m;
        @(posedge clk); #1; req_start = 2'b00;
    endtask

    task automatic send_bytes(input int p, input int n, input bit stop_last);
        int w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            do begin @(negedge clk); w++; end
            while (req_data_req[p] !== 1'b1 && w < 2000);
            if (w >= 2000) begin
                checks++; errors++;
                $display("FAIL data_req_wait p%0d byte%0d: req_data_req=%b want 1", p, i, req_data_req[p]);
                return;
            end
            @(posedge clk); #1;
            req_valid[p] = 1'b1;
            req_stop[p] = stop_last && (i == n - 1);
            if (p == 0) req_data0 = tx0[i]; else req_data1 = tx1[i];
            @(posedge clk); #1;
            req_valid[p] = 1'b0;
            req_stop[p] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(req_busy == 2'b00 && grant == 2'b00) && n < 3000);
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL idle_wait: req_busy=%b grant=%b want 00/00", req_busy, grant);
        end
    endtask

    task automatic run_txn(input int p, input int n);
        gen(p, n, -1, 0);
        pulse(oh(p));
        send_bytes(p, n, 1);
        wait_idle();
        rr_m = p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (grant !== 2'b00 || m_start !== 1'b0 || txn_abort !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: grant=%b m_start=%b abort=%b want 00/0/0", grant, m_start, txn_abort);
        end
        checks++;
        if (req_data_req !== 2'b00 || req_busy !== 2'b00 || m_data_valid !== 1'b0 || m_stop !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: dreq=%b busy=%b mdv=%b mstop=%b want 0s",
                     req_data_req, req_busy, m_data_valid, m_stop);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        rr_m = 1;
    endtask

    task automatic test_single();
        int n, nb;
        clear_logs();
        gen(0, 52, 8'h78, 0);
        add_exp(0, 52, 1);
        @(posedge clk); #1; req_start = 2'b01;
        @(negedge clk);
        @(posedge clk); #1; req_start = 2'b00;
        @(negedge clk);
        checks++;
        if (m_start !== 1'b0) begin
            errors++; $display("FAIL start_lat1: m_start=%b want 0", m_start);
        end
        @(negedge clk);
        checks++;
        if (m_start !== 1'b1 || grant !== 2'b01) begin
            errors++; $display("FAIL start_lat2: m_start=%b grant=%b want 1/01", m_start, grant);
        end
        send_bytes(0, 52, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (m_busy !== 1'b0 && n < 100);
        checks++;
        if (n >= 100 || grant !== 2'b01) begin
            errors++; $display("FAIL drain_hold: grant=%b n=%0d want 01 on busy fall", grant, n);
        end
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin
            errors++; $display("FAIL drain_release: grant=%b want 00", grant);
        end
        nb = 0;
        foreach (exp_q[i]) if (i >= log_q.size() || log_q[i] !== exp_q[i]) nb++;
        checks++;
        if (nb != 0 || log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_bytes: got %0d bytes %0d bad, want %0d bytes 0 bad",
                     log_q.size(), nb, exp_q.size());
        end
        rr_m = 0;
    endtask

    task automatic collide(input string nm);
        int w, l, nb;
        clear_logs();
        w = pick(2'b11, rr_m);
        l = 1 - w;
        gen(0, $urandom_range(3, 8), -1, 0);
        gen(1, $urandom_range(3, 8), -1, 0);
        add_exp(w, (w == 0) ? tx0.size() : tx1.size(), 1);
        add_exp(l, (l == 0) ? tx0.size() : tx1.size(), 1);
        exp_st.push_back(oh(w));
        exp_st.push_back(oh(l));
        pulse(2'b11);
        fork
            send_bytes(0, tx0.size(), 1);
            send_bytes(1, tx1.size(), 1);
        join
        wait_idle();
        checks++;
        if (st_q.size() != 2 || st_q[0] !== exp_st[0] || st_q[1] !== exp_st[1]) begin
            errors++;
            $display("FAIL %s_order: starts=%0d first=%b want 2 first=%b",
                     nm, st_q.size(), (st_q.size() > 0) ? st_q[0] : 2'bxx, exp_st[0]);
        end
        nb = 0;
        foreach (exp_q[i]) if (i >= log_q.size() || log_q[i] !== exp_q[i]) nb++;
        checks++;
        if (nb != 0 || log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_bytes: got %0d bytes %0d bad, want %0d", nm, log_q.size(), nb, exp_q.size());
        end
        rr_m = l;
    endtask

    task automatic test_collision();
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        rr_m = 1;
        collide("coll1");
        run_txn(0, 4);
        collide("coll2");
    endtask

    task automatic test_interference();
        int nb, bad_dreq, bad_busy, n_ff;
        clear_logs();
        gen(0, 52, -1, 1);
        add_exp(0, 52, 1);
        bad_dreq = 0; bad_busy = 0;
        pulse(2'b01);
        fork
            send_bytes(0, 52, 1);
            begin
                for (int k = 0; k < 60; k++) begin
                    @(posedge clk); #1;
                    req_valid[1] = (grant == 2'b01) ? ~req_valid[1] : 1'b0;
                    req_stop[1] = 1'($urandom);
                    req_data1 = 8'hFF;
                    @(negedge clk);
                    if (grant == 2'b01 && req_data_req[1] !== 1'b0) bad_dreq++;
                    if (grant == 2'b01 && req_busy[1] !== 1'b1) bad_busy++;
                end
                @(posedge clk); #1;
                req_valid[1] = 1'b0; req_stop[1] = 1'b0;
            end
        join
        wait_idle();
        checks++;
        if (bad_dreq != 0) begin
            errors++; $display("FAIL nonowner_dreq: %0d cycles with req_data_req[1]=1, want 0", bad_dreq);
        end
        checks++;
        if (bad_busy != 0) begin
            errors++; $display("FAIL nonowner_busy: %0d cycles with req_busy[1]=0, want 0", bad_busy);
        end
        n_ff = 0;
        foreach (log_q[i]) if (log_q[i][7:0] == 8'hFF) n_ff++;
        checks++;
        if (n_ff != 0 || st_q.size() != 1) begin
            errors++; $display("FAIL nonowner_leak: ff_bytes=%0d starts=%0d want 0/1", n_ff, st_q.size());
        end
        nb = 0;
        foreach (exp_q[i]) if (i >= log_q.size() || log_q[i] !== exp_q[i]) nb++;
        checks++;
        if (nb != 0 || log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL interf_bytes: got %0d bytes %0d bad, want %0d", log_q.size(), nb, exp_q.size());
        end
        rr_m = 0;
    endtask

    task automatic test_dup_start();
        int nb, n;
        clear_logs();
        gen(0, 20, -1, 0);
        gen(1, 4, -1, 0);
        add_exp(0, 20, 1);
        add_exp(1, 4, 1);
        exp_st.push_back(oh(0));
        exp_st.push_back(oh(pick(2'b10, rr_m)));
        pulse(2'b01);
        fork
            send_bytes(0, 20, 1);
            begin
                n = 0;
                do begin @(negedge clk); n++; end while (grant !== 2'b01 && n < 50);
                repeat (3) begin
                    pulse(2'b10);
                    @(posedge clk);
                end
                send_bytes(1, 4, 1);
            end
        join
        wait_idle();
        repeat (20) @(negedge clk);
        checks++;
        if (st_q.size() != 2 || st_q[0] !== exp_st[0] || st_q[1] !== exp_st[1]) begin
            errors++;
            $display("FAIL dup_start: starts=%0d last=%b want 2 last=%b",
                     st_q.size(), (st_q.size() > 0) ? st_q[st_q.size()-1] : 2'bxx, exp_st[1]);
        end
        nb = 0;
        foreach (exp_q[i]) if (i >= log_q.size() || log_q[i] !== exp_q[i]) nb++;
        checks++;
        if (nb != 0 || log_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL dup_bytes: got %0d bytes %0d bad, want %0d", log_q.size(), nb, exp_q.size());
        end
        rr_m = 1;
    endtask

    task automatic test_reset_mid();
        clear_logs();
        gen(0, 30, -1, 0);
        pulse(2'b01);
        send_bytes(0, 10, 0);
        pulse(2'b10);
        @(negedge clk);
        checks++;
        if (req_busy !== 2'b11 || grant !== 2'b01) begin
            errors++; $display("FAIL pre_reset: busy=%b grant=%b want 11/01", req_busy, grant);
        end
        @(posedge clk); #1; rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00 || m_start !== 1'b0 || req_data_req !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: grant=%b m_start=%b dreq=%b want 00/0/00", grant, m_start, req_data_req);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (req_busy !== 2'b00) begin
            errors++; $display("FAIL reset_pending: req_busy=%b want 00", req_busy);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        st_q.delete();
        repeat (20) @(negedge clk);
        checks++;
        if (st_q.size() != 0 || grant !== 2'b00) begin
            errors++; $display("FAIL post_reset: starts=%0d grant=%b want 0/00", st_q.size(), grant);
        end
        rr_m = 1;
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int k_ab, nab;
        logic a_v, a_s;
        logic [7:0] a_d;
        logic [1:0] a_r;
        clear_logs();
        gen(0, 10, -1, 0);
        add_exp(0, 3, 0);
        exp_q.push_back({2'b01, 1'b1, 8'h00});
        pulse(2'b01);
        send_bytes(0, 3, 0);
        k_ab = -1; nab = 0;
        a_v = 1'b0; a_s = 1'b0; a_d = 8'hxx; a_r = 2'bxx;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (txn_abort === 1'b1) begin
                nab++;
                if (k_ab < 0) begin
                    k_ab = k; a_v = m_data_valid; a_s = m_stop; a_d = m_data; a_r = req_data_req;
                end
            end
        end
        checks++;
        if (k_ab != TO + 1 || nab != 1) begin
            errors++;
            $display("FAIL abort_time: at %0d cycles after last byte, %0d pulses; want %0d, 1",
                     k_ab, nab, TO + 1);
        end
        checks++;
        if (a_v !== 1'b1 || a_s !== 1'b1 || a_d !== 8'h00 || a_r !== 2'b00) begin
            errors++;
            $display("FAIL abort_byte: v=%b stop=%b d=%h dreq=%b want 1/1/00/00", a_v, a_s, a_d, a_r);
        end
        wait_idle();
        repeat (10) @(negedge clk);
        checks++;
        if (log_q.size() != 4 || log_q[3] !== exp_q[3] || log_q[0] !== exp_q[0]
            || st_q.size() != 1 || req_busy !== 2'b00) begin
            errors++;
            $display("FAIL abort_cleanup: bytes=%0d starts=%0d busy=%b want 4/1/00",
                     log_q.size(), st_q.size(), req_busy);
        end
        rr_m = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_collision();
        test_interference();
        test_dup_start();
        test_reset_mid();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
